clock_alarm_core: RTL and testbench

//  Parametrised time-keeping core for the 7-seg clock; successor to the fixed hh:mm:ss register.

---
 rtl/clock_pkg.sv | 33 +++
 rtl/clock_alarm_channel.sv | 58 +++++
 rtl/clock_alarm_core.sv | 141 ++++++++++++++
 tb/tb_clock_alarm_core.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// clock_pkg: shared field widths, alarm state encoding and 12 h display conversion.
package clock_pkg;

    localparam int HOURS_W = 5;
    localparam int MIN_W   = 6;
    localparam int SEC_W   = 6;

    typedef enum logic [1:0] {
        ALM_IDLE    = 2'd0,
        ALM_RINGING = 2'd1,
        ALM_SNOOZE  = 2'd2
    } alarm_state_e;

    typedef struct packed {
        logic               pm;
        logic [HOURS_W-1:0] hours;
    } disp_hours_t;

    typedef struct packed {
        logic [HOURS_W-1:0] hours;
        logic [MIN_W-1:0]   minutes;
        logic               pm;
        logic [SEC_W-1:0]   seconds;
    } disp_state_t;

    function automatic disp_hours_t to_12h(input logic [HOURS_W-1:0] h);
        disp_hours_t r;
        r.pm    = h >= HOURS_W'(12);
        r.hours = (h == '0) ? HOURS_W'(12) : (h > HOURS_W'(12) ? h - HOURS_W'(12) : h);
        return r;
    endfunction

endpackage

// File: rtl/clock_alarm_channel.sv
// clock_alarm_channel: one alarm channel FSM with a shared ring/snooze countdown.
module clock_alarm_channel
    import clock_pkg::*;
#(
    parameter int SNOOZE_S       = 300,
    parameter int RING_TIMEOUT_S = 60
)(
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_en,
    input  logic i_tick,
    input  logic i_match,
    input  logic i_snooze,
    input  logic i_dismiss,
    input  logic i_chan_en,
    output logic o_ringing
);

    localparam int CW = $clog2(((SNOOZE_S > RING_TIMEOUT_S) ? SNOOZE_S : RING_TIMEOUT_S) + 1);
    localparam logic [CW-1:0] SNZ_LOAD  = CW'(SNOOZE_S);
    localparam logic [CW-1:0] RING_LOAD = CW'(RING_TIMEOUT_S);

    alarm_state_e    state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (i_en) begin
            if (state_q != ALM_IDLE && (!i_chan_en || i_dismiss)) begin
                state_d = ALM_IDLE;
            end else if (state_q == ALM_RINGING && i_snooze) begin
                state_d = ALM_SNOOZE;
                cnt_d   = SNZ_LOAD;
            end else if (state_q != ALM_IDLE && i_tick) begin
                // The last tick of either phase flips ringing<->idle or snooze->ringing.
                state_d = (cnt_q > CW'(1)) ? state_q : (state_q == ALM_RINGING ? ALM_IDLE : ALM_RINGING);
                cnt_d   = (cnt_q > CW'(1)) ? cnt_q - CW'(1) : RING_LOAD;
            end else if (state_q == ALM_IDLE && i_match && i_chan_en) begin
                state_d = ALM_RINGING;
                cnt_d   = RING_LOAD;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ALM_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_ringing = state_q == ALM_RINGING;

endmodule

// File: rtl/clock_alarm_core.sv
// clock_alarm_core: 24 h timekeeping, alarm channels, 12/24 h display mux and display handshake.
module clock_alarm_core
    import clock_pkg::*;
#(
    parameter int NUM_ALARMS     = 2,
    parameter int SNOOZE_S       = 300,
    parameter int RING_TIMEOUT_S = 60,
    localparam int AW            = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
)(
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_en,
    input  logic                  i_1hz_stb,
    input  logic                  i_set_stb,
    input  logic                  i_set_hours,
    input  logic                  i_set_minutes,
    input  logic                  i_alarm_set,
    input  logic [AW-1:0]         i_alarm_sel,
    input  logic [NUM_ALARMS-1:0] i_alarm_en,
    input  logic                  i_mode_12h,
    input  logic                  i_snooze,
    input  logic                  i_dismiss,
    input  logic                  i_disp_ack,
    output logic [HOURS_W-1:0]    o_hours,
    output logic [MIN_W-1:0]      o_minutes,
    output logic [SEC_W-1:0]      o_seconds,
    output logic [HOURS_W-1:0]    o_disp_hours,
    output logic [MIN_W-1:0]      o_disp_minutes,
    output logic                  o_pm,
    output logic [NUM_ALARMS-1:0] o_ringing,
    output logic                  o_buzz,
    output logic                  o_disp_req
);

    logic [HOURS_W-1:0] hours_q, hours_d;
    logic [MIN_W-1:0]   minutes_q, minutes_d;
    logic [SEC_W-1:0]   seconds_q, seconds_d;
    logic [HOURS_W-1:0] alm_hours_q [NUM_ALARMS];
    logic [HOURS_W-1:0] alm_hours_d [NUM_ALARMS];
    logic [MIN_W-1:0]   alm_minutes_q [NUM_ALARMS];
    logic [MIN_W-1:0]   alm_minutes_d [NUM_ALARMS];
    disp_state_t        disp_prev_q, disp_prev_d, disp_now;
    logic               disp_req_q, disp_req_d, first_q, first_d;
    logic               time_set, tick, set_time, set_alm, sel_ok, rollover;
    logic [HOURS_W-1:0] src_hours;
    disp_hours_t        src_12h;
    logic [NUM_ALARMS-1:0] match;

    assign sel_ok   = int'(i_alarm_sel) < NUM_ALARMS;
    assign time_set = !i_alarm_set && (i_set_hours || i_set_minutes);
    assign tick     = i_en && i_1hz_stb && !time_set;
    assign set_time = i_en && i_set_stb && time_set;
    assign set_alm  = i_en && i_set_stb && i_alarm_set && sel_ok;
    assign rollover = tick && seconds_q == SEC_W'(59);

    always_comb begin
        hours_d   = hours_q;
        minutes_d = minutes_q;
        seconds_d = seconds_q;
        if (set_time) begin
            seconds_d = '0;
            minutes_d = i_set_minutes ? ((minutes_q == MIN_W'(59)) ? '0 : minutes_q + MIN_W'(1)) : minutes_q;
            hours_d   = i_set_hours ? ((hours_q == HOURS_W'(23)) ? '0 : hours_q + HOURS_W'(1)) : hours_q;
        end else if (tick) begin
            seconds_d = (seconds_q == SEC_W'(59)) ? '0 : seconds_q + SEC_W'(1);
            if (seconds_q == SEC_W'(59)) begin
                minutes_d = (minutes_q == MIN_W'(59)) ? '0 : minutes_q + MIN_W'(1);
                hours_d   = (minutes_q != MIN_W'(59)) ? hours_q : ((hours_q == HOURS_W'(23)) ? '0 : hours_q + HOURS_W'(1));
            end
        end
    end

    always_comb begin
        alm_hours_d   = alm_hours_q;
        alm_minutes_d = alm_minutes_q;
        if (set_alm && i_set_hours)
            alm_hours_d[i_alarm_sel] = (alm_hours_q[i_alarm_sel] == HOURS_W'(23)) ? '0 : alm_hours_q[i_alarm_sel] + HOURS_W'(1);
        if (set_alm && i_set_minutes)
            alm_minutes_d[i_alarm_sel] = (alm_minutes_q[i_alarm_sel] == MIN_W'(59)) ? '0 : alm_minutes_q[i_alarm_sel] + MIN_W'(1);
    end

    // Matches compare the post-tick time so the alarm fires on the hh:mm:00 edge.
    for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_chan
        assign match[i] = rollover && hours_d == alm_hours_q[i] && minutes_d == alm_minutes_q[i];
        clock_alarm_channel #(
            .SNOOZE_S       (SNOOZE_S),
            .RING_TIMEOUT_S (RING_TIMEOUT_S)
        ) u_chan (
            .i_clk     (i_clk),
            .i_reset   (i_reset),
            .i_en      (i_en),
            .i_tick    (tick),
            .i_match   (match[i]),
            .i_snooze  (i_snooze),
            .i_dismiss (i_dismiss),
            .i_chan_en (i_alarm_en[i]),
            .o_ringing (o_ringing[i])
        );
    end

    always_comb begin
        src_hours      = (i_alarm_set && sel_ok) ? alm_hours_q[i_alarm_sel] : hours_q;
        o_disp_minutes = (i_alarm_set && sel_ok) ? alm_minutes_q[i_alarm_sel] : minutes_q;
        src_12h        = to_12h(src_hours);
        o_disp_hours   = i_mode_12h ? src_12h.hours : src_hours;
        o_pm           = i_mode_12h && src_12h.pm;
        disp_now       = '{hours: o_disp_hours, minutes: o_disp_minutes, pm: o_pm, seconds: seconds_q};
        disp_prev_d    = i_en ? disp_now : disp_prev_q;
        first_d        = i_en ? 1'b0 : first_q;
        disp_req_d     = i_en ? (first_q || disp_now != disp_prev_q || (disp_req_q && !i_disp_ack)) : disp_req_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            hours_q       <= '0;
            minutes_q     <= '0;
            seconds_q     <= '0;
            alm_hours_q   <= '{default: '0};
            alm_minutes_q <= '{default: '0};
            disp_prev_q   <= '0;
            disp_req_q    <= 1'b0;
            first_q       <= 1'b1;
        end else begin
            hours_q       <= hours_d;
            minutes_q     <= minutes_d;
            seconds_q     <= seconds_d;
            alm_hours_q   <= alm_hours_d;
            alm_minutes_q <= alm_minutes_d;
            disp_prev_q   <= disp_prev_d;
            disp_req_q    <= disp_req_d;
            first_q       <= first_d;
        end
    end

    assign o_hours    = hours_q;
    assign o_minutes  = minutes_q;
    assign o_seconds  = seconds_q;
    assign o_buzz     = |o_ringing;
    assign o_disp_req = disp_req_q;

endmodule

// File: tb/tb_clock_alarm_core.sv
// tb_clock_alarm_core: directed and randomized checks against a seconds-of-day reference model.
module tb_clock_alarm_core;

    localparam int N  = 2;
    localparam int SN = 5;
    localparam int RT = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1, en = 1'b1, hz = 1'b0, set_stb = 1'b0, set_h = 1'b0, set_m = 1'b0;
    logic         alarm_set = 1'b0, mode12 = 1'b0, snooze = 1'b0, dismiss = 1'b0, ack = 1'b0;
    logic [0:0]   sel = 1'b0;
    logic [N-1:0] alm_en = '0;
    logic [4:0]   hours, disp_hours;
    logic [5:0]   minutes, seconds, disp_minutes;
    logic         pm, buzz, disp_req;
    logic [N-1:0] ringing;

    int checks = 0;
    int fails  = 0;

    int mt;
    int mah [N];
    int mam [N];
    int ring_left [N];
    int snz_left [N];

    always #5 clk = ~clk;

    clock_alarm_core #(.NUM_ALARMS(N), .SNOOZE_S(SN), .RING_TIMEOUT_S(RT)) dut (
        .i_clk(clk), .i_reset(reset), .i_en(en), .i_1hz_stb(hz), .i_set_stb(set_stb),
        .i_set_hours(set_h), .i_set_minutes(set_m), .i_alarm_set(alarm_set), .i_alarm_sel(sel),
        .i_alarm_en(alm_en), .i_mode_12h(mode12), .i_snooze(snooze), .i_dismiss(dismiss),
        .i_disp_ack(ack), .o_hours(hours), .o_minutes(minutes), .o_seconds(seconds),
        .o_disp_hours(disp_hours), .o_disp_minutes(disp_minutes), .o_pm(pm),
        .o_ringing(ringing), .o_buzz(buzz), .o_disp_req(disp_req)
    );

    task automatic model_step();
        bit tset, tk, rolled;
        int h, m;
        int oh [N];
        int om [N];
        if (reset) begin
            mt = 0;
            for (int c = 0; c < N; c++) begin
                mah[c] = 0; mam[c] = 0; ring_left[c] = 0; snz_left[c] = 0;
            end
            return;
        end
        if (!en) return;
        for (int c = 0; c < N; c++) begin oh[c] = mah[c]; om[c] = mam[c]; end
        tset   = !alarm_set && (set_h || set_m);
        tk     = hz && !tset;
        rolled = 0;
        if (set_stb && tset) begin
            h = mt / 3600; m = (mt / 60) % 60;
            if (set_h) h = (h + 1) % 24;
            if (set_m) m = (m + 1) % 60;
            mt = h * 3600 + m * 60;
        end else if (tk) begin
            mt = (mt + 1) % 86400;
            rolled = (mt % 60) == 0;
        end
        for (int c = 0; c < N; c++) begin
            if ((ring_left[c] > 0 || snz_left[c] > 0) && (!alm_en[c] || dismiss)) begin
                ring_left[c] = 0; snz_left[c] = 0;
            end else if (ring_left[c] > 0 && snooze) begin
                ring_left[c] = 0; snz_left[c] = SN;
            end else if (ring_left[c] > 0) begin
                if (tk) ring_left[c]--;
            end else if (snz_left[c] > 0) begin
                if (tk) begin
                    snz_left[c]--;
                    if (snz_left[c] == 0) ring_left[c] = RT;
                end
            end else if (rolled && alm_en[c] && mt / 60 == oh[c] * 60 + om[c]) begin
                ring_left[c] = RT;
            end
        end
        if (set_stb && alarm_set && int'(sel) < N) begin
            if (set_h) mah[sel] = (mah[sel] + 1) % 24;
            if (set_m) mam[sel] = (mam[sel] + 1) % 60;
        end
    endtask

    function automatic logic [N-1:0] exp_ring();
        logic [N-1:0] r;
        for (int c = 0; c < N; c++) r[c] = ring_left[c] > 0;
        return r;
    endfunction

    function automatic int src_h();
        return alarm_set ? mah[sel] : mt / 3600;
    endfunction

    function automatic int exp_dh();
        int s = src_h();
        return !mode12 ? s : (s == 0 ? 12 : (s > 12 ? s - 12 : s));
    endfunction

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        hz = 1'b1; cyc(); hz = 1'b0;
    endtask

    task automatic drain();
        repeat (2) cyc();
        ack = 1'b1; cyc(); ack = 1'b0; cyc();
    endtask

    task automatic set_time(input int h, input int m, input int s);
        int n;
        alarm_set = 1'b0;
        n = (h - mt / 3600 + 24) % 24;
        set_h = 1'b1; set_stb = 1'b1; repeat (n) cyc(); set_stb = 1'b0; set_h = 1'b0;
        n = (m - (mt / 60) % 60 + 60) % 60;
        if (n == 0) n = 60;
        set_m = 1'b1; set_stb = 1'b1; repeat (n) cyc(); set_stb = 1'b0; set_m = 1'b0;
        repeat (s) tick();
    endtask

    task automatic set_alarm(input int c, input int h, input int m);
        int n;
        alarm_set = 1'b1; sel = 1'(c);
        n = (h - mah[c] + 24) % 24;
        set_h = 1'b1; set_stb = 1'b1; repeat (n) cyc(); set_stb = 1'b0; set_h = 1'b0;
        n = (m - mam[c] + 60) % 60;
        set_m = 1'b1; set_stb = 1'b1; repeat (n) cyc(); set_stb = 1'b0; set_m = 1'b0;
        alarm_set = 1'b0; sel = 1'b0;
    endtask

    task automatic ring0();
        set_time(7, 29, 59);
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; cyc(); cyc();
        checks++;
        if ({hours, minutes, seconds} !== 17'd0) begin
            fails++; $display("FAIL reset_time got %0d:%0d:%0d want 0:0:0", hours, minutes, seconds);
        end
        checks++;
        if (ringing !== '0 || buzz !== 1'b0) begin
            fails++; $display("FAIL reset_ring got ringing=%b buzz=%b want 00/0", ringing, buzz);
        end
        checks++;
        if (disp_req !== 1'b0) begin
            fails++; $display("FAIL reset_req got %b want 0", disp_req);
        end
        reset = 1'b0; cyc();
        checks++;
        if (disp_req !== 1'b1) begin
            fails++; $display("FAIL first_draw_req got %b want 1", disp_req);
        end
    endtask

    task automatic test_rollover();
        set_time(23, 59, 58);
        drain();
        checks++;
        if (disp_req !== 1'b0) begin
            fails++; $display("FAIL ack_clears_req got %b want 0", disp_req);
        end
        tick();
        checks++;
        if (hours !== 5'd23 || minutes !== 6'd59 || seconds !== 6'd59) begin
            fails++; $display("FAIL roll_235959 got %0d:%0d:%0d want 23:59:59", hours, minutes, seconds);
        end
        cyc();
        checks++;
        if (disp_req !== 1'b1) begin
            fails++; $display("FAIL roll_req1 got %b want 1", disp_req);
        end
        drain();
        tick();
        checks++;
        if ({hours, minutes, seconds} !== 17'd0) begin
            fails++; $display("FAIL roll_000000 got %0d:%0d:%0d want 0:0:0", hours, minutes, seconds);
        end
        cyc();
        checks++;
        if (disp_req !== 1'b1) begin
            fails++; $display("FAIL roll_req2 got %b want 1", disp_req);
        end
    endtask

    task automatic test_set();
        set_time(12, 59, 30);
        set_m = 1'b1; set_stb = 1'b1; cyc(); set_stb = 1'b0;
        checks++;
        if (hours !== 5'd12 || minutes !== 6'd0 || seconds !== 6'd0) begin
            fails++; $display("FAIL set_min_wrap got %0d:%0d:%0d want 12:0:0", hours, minutes, seconds);
        end
        tick(); tick();
        checks++;
        if (hours !== 5'd12 || minutes !== 6'd0 || seconds !== 6'd0) begin
            fails++; $display("FAIL set_hold_ignores_1hz got %0d:%0d:%0d want 12:0:0", hours, minutes, seconds);
        end
        set_h = 1'b1; set_stb = 1'b1; cyc(); set_stb = 1'b0; set_h = 1'b0; set_m = 1'b0;
        checks++;
        if (hours !== 5'd13 || minutes !== 6'd1 || seconds !== 6'd0) begin
            fails++; $display("FAIL set_both got %0d:%0d:%0d want 13:1:0", hours, minutes, seconds);
        end
    endtask

    task automatic test_enable();
        set_time(10, 20, 30);
        en = 1'b0; hz = 1'b1; set_stb = 1'b1; set_h = 1'b1;
        repeat (3) cyc();
        hz = 1'b0; set_stb = 1'b0; set_h = 1'b0; en = 1'b1;
        checks++;
        if (hours !== 5'd10 || minutes !== 6'd20 || seconds !== 6'd30) begin
            fails++; $display("FAIL en0_freeze got %0d:%0d:%0d want 10:20:30", hours, minutes, seconds);
        end
    endtask

    task automatic test_alarm();
        alm_en = 2'b01;
        set_alarm(0, 7, 30);
        set_time(7, 29, 59);
        checks++;
        if (ringing !== 2'b00) begin
            fails++; $display("FAIL alarm_pre got %b want 00", ringing);
        end
        tick();
        checks++;
        if (ringing !== 2'b01 || buzz !== 1'b1) begin
            fails++; $display("FAIL alarm_fire got ringing=%b buzz=%b want 01/1", ringing, buzz);
        end
        repeat (RT - 1) tick();
        checks++;
        if (ringing !== 2'b01) begin
            fails++; $display("FAIL alarm_before_timeout got %b want 01", ringing);
        end
        tick();
        checks++;
        if (ringing !== 2'b00 || buzz !== 1'b0) begin
            fails++; $display("FAIL alarm_timeout got ringing=%b buzz=%b want 00/0", ringing, buzz);
        end
    endtask

    task automatic test_snooze();
        ring0();
        snooze = 1'b1; cyc(); snooze = 1'b0;
        checks++;
        if (ringing !== 2'b00) begin
            fails++; $display("FAIL snooze_stops got %b want 00", ringing);
        end
        repeat (SN - 1) tick();
        checks++;
        if (ringing !== 2'b00) begin
            fails++; $display("FAIL snooze_early got %b want 00", ringing);
        end
        tick();
        checks++;
        if (ringing !== 2'b01) begin
            fails++; $display("FAIL snooze_expire got %b want 01", ringing);
        end
        dismiss = 1'b1; cyc(); dismiss = 1'b0;
        repeat (SN + 1) tick();
        checks++;
        if (ringing !== 2'b00) begin
            fails++; $display("FAIL dismiss got %b want 00", ringing);
        end
        ring0();
        checks++;
        if (ringing !== 2'b01) begin
            fails++; $display("FAIL retrigger got %b want 01", ringing);
        end
        snooze = 1'b1; dismiss = 1'b1; cyc(); snooze = 1'b0; dismiss = 1'b0;
        repeat (SN + 1) tick();
        checks++;
        if (ringing !== 2'b00) begin
            fails++; $display("FAIL snooze_and_dismiss got %b want 00", ringing);
        end
        ring0();
        alm_en = 2'b00; cyc(); alm_en = 2'b01;
        checks++;
        if (ringing !== 2'b00) begin
            fails++; $display("FAIL disable_stops got %b want 00", ringing);
        end
    endtask

    task automatic test_12h();
        mode12 = 1'b1;
        set_time(0, 5, 0);
        checks++;
        if (disp_hours !== 5'd12 || pm !== 1'b0) begin
            fails++; $display("FAIL h12_midnight got %0d pm=%b want 12 pm=0", disp_hours, pm);
        end
        set_time(12, 5, 0);
        checks++;
        if (disp_hours !== 5'd12 || pm !== 1'b1) begin
            fails++; $display("FAIL h12_noon got %0d pm=%b want 12 pm=1", disp_hours, pm);
        end
        set_time(13, 5, 0);
        checks++;
        if (disp_hours !== 5'd1 || pm !== 1'b1) begin
            fails++; $display("FAIL h12_13 got %0d pm=%b want 1 pm=1", disp_hours, pm);
        end
        mode12 = 1'b0; #1;
        checks++;
        if (disp_hours !== 5'd13 || pm !== 1'b0) begin
            fails++; $display("FAIL h24_13 got %0d pm=%b want 13 pm=0", disp_hours, pm);
        end
        set_alarm(1, 17, 42);
        alarm_set = 1'b1; sel = 1'b1; mode12 = 1'b1; #1;
        checks++;
        if (disp_hours !== 5'd5 || disp_minutes !== 6'd42 || pm !== 1'b1) begin
            fails++; $display("FAIL alarm1_disp got %0d:%0d pm=%b want 5:42 pm=1", disp_hours, disp_minutes, pm);
        end
        tick();
        checks++;
        if (hours !== 5'd13 || minutes !== 6'd5 || seconds !== 6'd1 || disp_minutes !== 6'd42) begin
            fails++; $display("FAIL alarm_set_time_runs got %0d:%0d:%0d dm=%0d want 13:5:1 dm=42", hours, minutes, seconds, disp_minutes);
        end
        alarm_set = 1'b0; sel = 1'b0; mode12 = 1'b0;
    endtask

    task automatic test_handshake();
        drain();
        tick(); cyc();
        checks++;
        if (disp_req !== 1'b1) begin
            fails++; $display("FAIL hs_pending got %b want 1", disp_req);
        end
        tick();
        ack = 1'b1; cyc(); ack = 1'b0;
        checks++;
        if (disp_req !== 1'b1) begin
            fails++; $display("FAIL hs_change_with_ack got %b want 1", disp_req);
        end
        cyc();
        checks++;
        if (disp_req !== 1'b1) begin
            fails++; $display("FAIL hs_hold got %b want 1", disp_req);
        end
        ack = 1'b1; cyc(); ack = 1'b0;
        checks++;
        if (disp_req !== 1'b0) begin
            fails++; $display("FAIL hs_ack_clear got %b want 0", disp_req);
        end
        ack = 1'b1; cyc(); ack = 1'b0; cyc();
        checks++;
        if (disp_req !== 1'b0) begin
            fails++; $display("FAIL hs_idle_ack got %b want 0", disp_req);
        end
    endtask

    task automatic test_reset_ringing();
        alm_en = 2'b01;
        ring0();
        checks++;
        if (ringing !== 2'b01) begin
            fails++; $display("FAIL rst_pre_ring got %b want 01", ringing);
        end
        reset = 1'b1; cyc(); reset = 1'b0;
        checks++;
        if (ringing !== 2'b00 || buzz !== 1'b0 || {hours, minutes, seconds} !== 17'd0 || disp_req !== 1'b0) begin
            fails++; $display("FAIL rst_mid got ring=%b buzz=%b t=%0d:%0d:%0d req=%b want 00/0 0:0:0 0", ringing, buzz, hours, minutes, seconds, disp_req);
        end
    endtask

    task automatic test_random();
        alm_en = 2'b11;
        set_alarm(0, 7, 0);
        set_alarm(1, 7, 1);
        set_time(6, 59, 50);
        for (int k = 0; k < 600; k++) begin
            en        = $urandom_range(19) != 0;
            hz        = $urandom_range(1);
            set_stb   = $urandom_range(9) == 0;
            set_h     = $urandom_range(29) == 0;
            set_m     = $urandom_range(29) == 0;
            alarm_set = $urandom_range(3) == 0;
            sel       = 1'($urandom_range(1));
            mode12    = $urandom_range(1);
            snooze    = $urandom_range(24) == 0;
            dismiss   = $urandom_range(39) == 0;
            ack       = $urandom_range(1);
            if ($urandom_range(59) == 0) alm_en = 2'($urandom_range(3));
            cyc();
            checks++;
            if (hours !== 5'(mt / 3600) || minutes !== 6'((mt / 60) % 60) || seconds !== 6'(mt % 60)) begin
                fails++; $display("FAIL rnd_time k=%0d got %0d:%0d:%0d want %0d:%0d:%0d", k, hours, minutes, seconds, mt / 3600, (mt / 60) % 60, mt % 60);
            end
            checks++;
            if (ringing !== exp_ring() || buzz !== |exp_ring()) begin
                fails++; $display("FAIL rnd_ring k=%0d got %b/%b want %b", k, ringing, buzz, exp_ring());
            end
            checks++;
            if (disp_hours !== 5'(exp_dh()) || pm !== (mode12 && src_h() >= 12) ||
                disp_minutes !== 6'(alarm_set ? mam[sel] : (mt / 60) % 60)) begin
                fails++; $display("FAIL rnd_disp k=%0d got %0d:%0d pm=%b want %0d:%0d", k, disp_hours, disp_minutes, pm, exp_dh(), alarm_set ? mam[sel] : (mt / 60) % 60);
            end
        end
        {en, hz, set_stb, set_h, set_m, alarm_set, snooze, dismiss, ack} = 9'b100000000;
    endtask

    initial begin
        test_reset();
        test_rollover();
        test_set();
        test_enable();
        test_alarm();
        test_snooze();
        test_12h();
        test_handshake();
        test_reset_ringing();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
